// File: rtl/lsu_ahb_pkg.sv
// Shared constants and state encoding for the LSU-to-AHB-lite bus master.
package lsu_ahb_pkg;

  localparam int AHB_ADDR_W  = 32;
  localparam int AHB_DATA_W  = 32;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = $clog2(TIMEOUT_DEF);

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CTRL = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_CTRL = ST_CTRL,
    S_ADDR = ST_ADDR,
    S_DATA = ST_DATA,
    S_RESP = ST_RESP
  } state_t;

  // Counter width able to hold TIMEOUT-1; never narrower than one bit.
  function automatic int cnt_width(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/lsu_ahb_master_wait_timer.sv
// Wait-cycle counter for the DATA phase: synchronous clear, count enable, terminal flag.
module ahb_wait_timer
  import lsu_ahb_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEF,
  parameter int W     = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] TC_VAL = W'(LIMIT - 2);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  // High on the wait cycle whose increment would land on LIMIT-1.
  assign tc = (count == TC_VAL);

endmodule

// File: rtl/lsu_ahb_master.sv
// Single-beat LSU request to three-phase (control, address, data) AHB-lite master.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module lsu_ahb_master
  import lsu_ahb_pkg::*;
#(
  parameter int ADDR_W  = AHB_ADDR_W,
  parameter int DATA_W  = AHB_DATA_W,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_we,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              hsel,
  output logic              hwrite,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata,
  output logic [2:0]        dbg_state
);

  state_t            state, next_state;
  logic              accept, misaligned;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              tmr_clr, tmr_en, tmr_tc, timed_out;

  assign dbg_state  = state;
  assign misaligned = (req_addr[1:0] & ALIGN_MASK) != 2'b00;
  assign tmr_en     = (state == S_DATA) && !hready;
  assign tmr_clr    = (state == S_IDLE) || ((state == S_RESP) && rsp_ready);
  assign timed_out  = tmr_en && tmr_tc;

  ahb_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept     = 1'b1;
          next_state = misaligned ? S_RESP : S_CTRL;
        end
      end
      S_CTRL:  next_state = S_ADDR;
      S_ADDR:  next_state = S_DATA;
      S_DATA:  if (hready || tmr_tc) next_state = S_RESP;
      S_RESP:  if (rsp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Every output is registered from next_state so it lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      hsel      <= 1'b0;
      hwrite    <= 1'b0;
      haddr     <= '0;
      hwdata    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == S_IDLE);
      rsp_valid <= (next_state == S_RESP);
      hsel      <= (next_state == S_CTRL);
      hwrite    <= (next_state == S_CTRL) && req_we;
      haddr     <= (next_state == S_ADDR) ? addr_q : '0;
      hwdata    <= ((next_state == S_DATA) && we_q) ? wdata_q : '0;

      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        we_q    <= req_we;
      end

      case (state)
        S_IDLE: begin
          if (accept && misaligned) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        S_DATA: begin
          // A slave reply on the terminal wait cycle beats the timeout.
          if (hready) begin
            rsp_rdata <= we_q ? '0 : hrdata;
            rsp_err   <= hresp;
          end else if (timed_out) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ahb_master.sv
// Bench for lsu_ahb_master: scripted transactions build a per-cycle expected trace from the bus rules.
module tb_lsu_ahb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct packed {
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          hsel;
    logic          hwrite;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwdata;
  } snap_t;

  localparam int SNAP_W = $bits(snap_t);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          hsel, hwrite, hready, hresp;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata, hrdata;
  logic [2:0]    dbg_state;

  lsu_ahb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hsel(hsel), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [SNAP_W-1:0] exp_q[$];
  logic [DW-1:0]     mem [logic [AW-1:0]];
  int                total = 0;
  int                bad = 0;
  int                cyc = 0;
  int                acc_cyc = 0;
  int                lat = -1;
  bit                rsp_open = 1'b0;
  logic [DW-1:0]     last_rdata = '0;
  logic              last_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic snap_t mk(input logic rr, input logic rv, input logic [DW-1:0] rd,
                               input logic re, input logic hs, input logic hw,
                               input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    snap_t s;
    s.req_ready = rr; s.rsp_valid = rv; s.rsp_rdata = rd; s.rsp_err = re;
    s.hsel = hs; s.hwrite = hw; s.haddr = ha; s.hwdata = hd;
    return s;
  endfunction

  snap_t idle_s, rst_s;

  // scoreboard: one expected snapshot per cycle, checked mid-cycle
  always @(negedge clk) begin
    snap_t e;
    cyc++;
    if (req_valid && req_ready) acc_cyc = cyc;
    if (rsp_valid && !rsp_open) begin
      lat      = cyc - acc_cyc;
      rsp_open = 1'b1;
    end
    if (!rsp_valid) rsp_open = 1'b0;
    if (rsp_valid && rsp_ready) begin
      last_rdata = rsp_rdata;
      last_err   = rsp_err;
    end
    if (exp_q.size() > 0) begin
      e = snap_t'(exp_q.pop_front());
      chk("req_ready", 32'(req_ready), 32'(e.req_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e.rsp_valid));
      chk("hsel",      32'(hsel),      32'(e.hsel));
      chk("hwrite",    32'(hwrite),    32'(e.hwrite));
      chk("haddr",     haddr,          e.haddr);
      chk("hwdata",    hwdata,         e.hwdata);
      if (e.rsp_valid) begin
        chk("rsp_rdata", rsp_rdata,      e.rsp_rdata);
        chk("rsp_err",   32'(rsp_err),   32'(e.rsp_err));
      end
    end
  end

  // driver tasks
  task automatic step(input snap_t e);
    exp_q.push_back(SNAP_W'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    req_valid = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_we    = 1'($urandom_range(0, 1));
    hready    = 1'($urandom_range(0, 1));
    hresp     = 1'($urandom_range(0, 1));
    hrdata    = $urandom;
    rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic we,
                         input int waits, input logic hr, input int dly, input int gap);
    logic [DW-1:0] rd, load_v;
    logic          err;
    int            n;
    bit            tmo;
    repeat (gap) begin
      noise(); req_valid = 1'b0; step(idle_s);
    end
    noise(); req_valid = 1'b1; req_addr = a; req_wdata = wd; req_we = we; step(idle_s);
    if (a % 4 != 0) begin
      rd = '0; err = 1'b1;
    end else begin
      noise(); step(mk(0, 0, '0, 0, 1, we, '0, '0));
      noise(); step(mk(0, 0, '0, 0, 0, 0, a, '0));
      tmo    = waits >= TO - 1;
      n      = tmo ? TO - 1 : waits + 1;
      load_v = mem.exists(a) ? mem[a] : $urandom;
      for (int i = 0; i < n; i++) begin
        noise();
        if (!tmo && i == n - 1) begin
          hready = 1'b1; hresp = hr; hrdata = load_v;
        end else begin
          hready = 1'b0;
        end
        step(mk(0, 0, '0, 0, 0, 0, '0, we ? wd : '0));
      end
      if (tmo) begin
        rd = '0; err = 1'b1;
      end else begin
        rd  = we ? '0 : load_v;
        err = hr;
        if (we && !hr) mem[a] = wd;
      end
    end
    for (int j = 0; j <= dly; j++) begin
      noise(); rsp_ready = (j == dly); step(mk(0, 1, rd, err, 0, 0, '0, '0));
    end
  endtask

  task automatic run_reset_in_addr(input logic [AW-1:0] a);
    noise(); req_valid = 1'b1; req_addr = a; req_we = 1'b0; step(idle_s);
    noise(); step(mk(0, 0, '0, 0, 1, 0, '0, '0));
    noise(); rst = 1'b1; step(mk(0, 0, '0, 0, 0, 0, a, '0));
    noise(); rst = 1'b0; step(rst_s);
  endtask

  initial begin
    logic [AW-1:0] a;
    int            r, w;
    idle_s = mk(1, 0, '0, 0, 0, 0, '0, '0);
    rst_s  = mk(0, 0, '0, 0, 0, 0, '0, '0);
    rst = 1'b1;
    noise();
    @(posedge clk);
    #1;
    repeat (3) begin noise(); step(rst_s); end
    rst = 1'b0;
    noise(); req_valid = 1'b0; step(rst_s);

    run_txn(32'hF0F0F0F0, 32'h12345678, 1'b1, 0, 1'b0, 0, 0);
    chk("store_latency", 32'(lat), 32'd4);
    chk("store_err", 32'(last_err), 32'd0);

    run_txn(32'hF0F0F0F0, $urandom, 1'b0, 0, 1'b0, 0, 0);
    chk("load_back_data", last_rdata, 32'h12345678);
    chk("load_latency", 32'(lat), 32'd4);

    run_txn(32'hF0F0F0F1, $urandom, 1'b0, 0, 1'b0, 0, 1);
    chk("misalign_latency", 32'(lat), 32'd1);
    chk("misalign_err", 32'(last_err), 32'd1);
    chk("misalign_data", last_rdata, 32'd0);

    run_txn(32'h0000_00A0, $urandom, 1'b0, 20, 1'b0, 0, 0);
    chk("timeout_latency", 32'(lat), 32'd18);
    chk("timeout_err", 32'(last_err), 32'd1);
    chk("timeout_data", last_rdata, 32'd0);

    run_txn(32'h0000_00A4, $urandom, 1'b0, 2, 1'b1, 0, 0);
    chk("hresp_latency", 32'(lat), 32'd6);
    chk("hresp_err", 32'(last_err), 32'd1);

    run_txn(32'h0000_00A8, $urandom, 1'b0, 14, 1'b0, 0, 0);
    chk("tc_race_latency", 32'(lat), 32'd18);
    chk("tc_race_err", 32'(last_err), 32'd0);

    run_txn(32'hF0F0F0F0, $urandom, 1'b0, 0, 1'b0, 5, 0);
    chk("stall_data", last_rdata, 32'h12345678);

    run_reset_in_addr(32'hF0F0F0F0);
    run_txn(32'hF0F0F0F0, $urandom, 1'b0, 0, 1'b0, 0, 0);
    chk("post_reset_data", last_rdata, 32'h12345678);
    chk("post_reset_err", 32'(last_err), 32'd0);

    for (int k = 0; k < 150; k++) begin
      a = 32'h0000_1000 + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      r = $urandom_range(0, 9);
      w = (r < 6) ? $urandom_range(0, 3) : (r < 8) ? $urandom_range(13, 16) : 0;
      run_txn(a, $urandom, 1'($urandom_range(0, 1)), w, ($urandom_range(0, 5) == 0),
              $urandom_range(0, 3), $urandom_range(0, 2));
    end

    noise(); req_valid = 1'b0; step(idle_s);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_ahb_master.md
Name: lsu_ahb_master

Overview:
Bus master that sits directly upstream of ram_top. It converts single-beat load/store requests from the core LSU (valid/ready handshake) into the team's three-phase AHB-lite slave sequence: control, then address, then data. It returns read data or an error to the LSU, and enforces an hready timeout so that a stuck slave cannot hang the core.

Parameters:
ADDR_W, 32 (`AHB_ADDR_WIDTH), address width
DATA_W, 32 (`AHB_DATA_WIDTH), data width
TIMEOUT, 16, max DATA-phase cycles waiting for hready before an error is forced (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  LSU request valid
req_ready  out  1  master can accept a request
req_addr  in  ADDR_W  byte address, must be word aligned
req_wdata  in  DATA_W  store data
req_we  in  1  1=store, 0=load
rsp_valid  out  1  response valid
rsp_ready  in  1  LSU accepts response
rsp_rdata  out  DATA_W  load data (0 for stores and errors)
rsp_err  out  1  bus error, timeout or misalignment
hsel  out  1  slave select (control phase)
hwrite  out  1  write flag (control phase)
haddr  out  ADDR_W  address (address phase)
hwdata  out  DATA_W  write data (data phase)
hready  in  1  slave ready
hresp  in  1  slave error
hrdata  in  DATA_W  slave read data

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE; hsel=0, hwrite=0, haddr=0, hwdata=0; req_ready=0 while rst=1; rsp_valid=0, rsp_rdata=0, rsp_err=0; wait counter=0.
- States: IDLE, CTRL, ADDR, DATA, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch addr, wdata and we.
  - addr[1:0]!=0: go to RESP with rsp_err=1 and rsp_rdata=0. No bus activity.
  - Otherwise: go to CTRL.
- CTRL (exactly 1 cycle): hsel=1, hwrite=we, haddr=0, hwdata=0. Next state is ADDR.
- ADDR (exactly 1 cycle): hsel=0, hwrite=0, haddr=latched addr. Next state is DATA.
- DATA:
  - haddr=0. hwdata=latched wdata if we=1, else 0.
  - Counter increments each cycle that hready=0.
  - On hready=1: capture rsp_rdata = we ? 0 : hrdata and rsp_err=hresp, then go to RESP.
  - If the counter reaches TIMEOUT-1 with hready=0: rsp_err=1, rsp_rdata=0, go to RESP.
  - hready and hresp arriving together with the timeout terminal count: the slave response wins.
- RESP:
  - rsp_valid=1, bus outputs are all 0, and rsp_rdata/rsp_err are held stable.
  - On rsp_ready=1: rsp_valid drops next cycle and state returns to IDLE. Counter is cleared.
- req_ready is 1 only in IDLE. There is no overlap between a response and the next request.
- Minimum latency:
  - Request accepted at edge 0; CTRL at cycle 1; ADDR at cycle 2; DATA at cycle 3 with hready=1.
  - rsp_valid is seen at cycle 4.
  - With rsp_ready held high, a new request is accepted at cycle 5, giving 5 cycles per transaction.
- hready and hresp are ignored outside DATA. hrdata is sampled only on the DATA hready cycle.
- rst asserted mid-transaction: all outputs take their reset values at that edge, and the in-flight request is dropped with no response.

Decomposition:
- Package lsu_ahb_pkg holds:
  - state enum (IDLE, CTRL, ADDR, DATA, RESP)
  - TIMEOUT default
  - counter width localparam $clog2(TIMEOUT)
  - ALIGN_MASK = 2'b11
- One sub-module, ahb_wait_timer: clear/enable counter with a terminal-count flag.
- The FSM and datapath stay in lsu_ahb_master.

Test Plan:
- Store: req addr=32'hF0F0F0F0, wdata=32'h12345678, we=1, with a ram_top model.
  - Expected: hsel=1,hwrite=1 at cycle 1; haddr=F0F0F0F0 at cycle 2; hwdata=12345678 at cycle 3; rsp_valid at cycle 4 with err=0.
- Load back from F0F0F0F0 (hready=1) -> rsp_rdata=32'h12345678, rsp_err=0.
- Misaligned load from 32'hF0F0F0F1 -> hsel never asserts; rsp_valid=1 with rsp_err=1 one cycle after accept.
- hready held 0 in DATA (TIMEOUT=16) -> rsp_err=1 and rsp_rdata=0 after 15 DATA cycles.
  - hready=1 plus hresp=1 on the 3rd DATA cycle -> rsp_err=1.
- rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout; the next request is accepted only after the handshake.
- rst pulsed high during ADDR -> next cycle all bus outputs are 0, rsp_valid=0, req_ready=0.
  - After rst falls: req_ready=1 and a fresh load completes normally.
